shift_deser: RTL and testbench

//   Serial-to-parallel receiver for the uC's internal bit-serial links. It samples a framed

---
 rtl/shift_deser.sv | 86 ++++++++
 tb/tb_shift_deser.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_deser.sv
// Framed serial-to-parallel receiver: start bit (0), WIDTH data bits, stop bit (1),
// sampled on a bit strobe and delivered on a valid/ready output with sticky error flags.
module shift_deser #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             in,
    input  logic             in_en,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    input  logic             ready,
    output logic             frame_err,
    output logic             overrun,
    input  logic             clr_err
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, DATA, STOP, HOLD} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shift_next;
    logic             stop_good;
    logic             stop_bad;
    logic             blocked;

    assign shift_next = MSB_FIRST ? {shreg[WIDTH-2:0], in} : {in, shreg[WIDTH-1:1]};
    assign stop_good  = in_en && (state == STOP) && in;
    assign stop_bad   = in_en && (state == STOP) && !in;
    // A word still waiting with no accept this cycle cannot be replaced.
    assign blocked    = valid && !ready;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (in_en) begin
                case (state)
                    IDLE: begin
                        if (!in) begin
                            state <= DATA;
                            cnt   <= '0;
                        end
                    end
                    DATA: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) state <= STOP;
                    end
                    STOP:    state <= in ? IDLE : HOLD;
                    HOLD:    if (in) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end

            if (stop_good && !blocked) begin
                data_out <= shreg;
                valid    <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end

            // Clear first so that a flag setting in the same cycle wins.
            if (clr_err) begin
                frame_err <= 1'b0;
                overrun   <= 1'b0;
            end
            if (stop_bad) frame_err <= 1'b1;
            if (stop_good && blocked) overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (in_en && (state == DATA)) shreg <= shift_next;
    end

endmodule

// File: tb/tb_shift_deser.sv
// Self-checking bench for shift_deser: directed scenarios plus randomized frames
// checked against a bit-order reference model.
module tb_shift_deser;

    localparam int WIDTH     = 8;
    localparam bit MSB_FIRST = 1'b0;

    logic             clk = 1'b0;
    logic             arst_n = 1'b0;
    logic             in_line = 1'b1;
    logic             in_en = 1'b0;
    logic             ready = 1'b0;
    logic             clr_err = 1'b0;
    logic [WIDTH-1:0] data_out;
    logic             valid;
    logic             frame_err;
    logic             overrun;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shift_deser #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) dut (
        .clk(clk), .arst_n(arst_n), .in(in_line), .in_en(in_en),
        .data_out(data_out), .valid(valid), .ready(ready),
        .frame_err(frame_err), .overrun(overrun), .clr_err(clr_err)
    );

    // seq[i] is the i-th data bit on the wire after the start bit.
    function automatic logic [WIDTH-1:0] model_word(input logic [WIDTH-1:0] seq);
        longint unsigned w = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (MSB_FIRST) w = w * 2 + seq[i];
            else           w = w + (longint'(seq[i]) << i);
        end
        return WIDTH'(w);
    endfunction

    function automatic logic [WIDTH-1:0] word_to_seq(input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] s;
        for (int i = 0; i < WIDTH; i++) s[i] = MSB_FIRST ? w[WIDTH-1-i] : w[i];
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One strobed bit, then 'gap' unstrobed cycles with the line toggled to garbage.
    task automatic send_bit(input logic b, input int gap);
        in_line = b;
        in_en   = 1'b1;
        tick();
        in_en = 1'b0;
        for (int g = 0; g < gap; g++) begin
            in_line = ~b;
            tick();
        end
    endtask

    task automatic send_head(input logic [WIDTH-1:0] seq, input int gap);
        send_bit(1'b0, gap);
        for (int i = 0; i < WIDTH; i++) send_bit(seq[i], gap);
    endtask

    task automatic idle(input int n);
        in_line = 1'b1;
        in_en   = 1'b1;
        for (int k = 0; k < n; k++) tick();
        in_en = 1'b0;
    endtask

    task automatic clear_flags();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    task automatic test_reset();
        arst_n = 1'b0; in_line = 1'b0; in_en = 1'b1;
        tick(); tick();
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_cmp++; if (data_out !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", data_out); end
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        arst_n = 1'b1; in_line = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_idle_valid: cycle %0d got %b want 0", k, valid); end
        end
        in_en = 1'b0;
    endtask

    task automatic test_basic();
        int frame [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        logic [WIDTH-1:0] seq;
        for (int i = 0; i < WIDTH; i++) seq[i] = frame[i+1][0];
        ready = 1'b1;
        idle(2);
        send_head(seq, 0);
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %b want 0", valid); end
        send_bit(frame[9][0], 0);
        n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", valid); end
        n_cmp++; if (data_out !== model_word(seq)) begin n_err++; $display("FAIL basic_data: got %h want %h", data_out, model_word(seq)); end
        tick();
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_drop: got %b want 0", valid); end
        idle(2);
    endtask

    task automatic test_slow_strobe();
        int frame [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        logic [WIDTH-1:0] seq;
        for (int i = 0; i < WIDTH; i++) seq[i] = frame[i+1][0];
        ready = 1'b1;
        send_head(seq, 3);
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL slow_early_valid: got %b want 0", valid); end
        send_bit(1'b1, 0);
        n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL slow_valid: got %b want 1", valid); end
        n_cmp++; if (data_out !== model_word(seq)) begin n_err++; $display("FAIL slow_data: got %h want %h", data_out, model_word(seq)); end
        idle(3);
    endtask

    task automatic test_frame_err();
        logic [WIDTH-1:0] prev;
        ready = 1'b1;
        prev = data_out === model_word(word_to_seq(data_out)) ? data_out : 'x;
        prev = model_word(word_to_seq(8'h4A));
        send_head(word_to_seq(8'h4A), 0);
        send_bit(1'b1, 0);
        idle(2);
        send_head(WIDTH'($urandom), 0);
        send_bit(1'b0, 0);
        n_cmp++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL ferr_set: got %b want 1", frame_err); end
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL ferr_valid: got %b want 0", valid); end
        n_cmp++; if (data_out !== prev) begin n_err++; $display("FAIL ferr_data_kept: got %h want %h", data_out, prev); end
        clear_flags();
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL ferr_clear1: got %b want 0", frame_err); end
        in_line = 1'b0; in_en = 1'b1;
        for (int k = 0; k < 12; k++) tick();
        in_en = 1'b0;
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL ferr_hold_err: got %b want 0", frame_err); end
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL ferr_hold_valid: got %b want 0", valid); end
        send_bit(1'b1, 0);
        idle(2);
        send_head(word_to_seq(8'hA5), 0);
        send_bit(1'b1, 0);
        n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL ferr_recover_valid: got %b want 1", valid); end
        n_cmp++; if (data_out !== 8'hA5) begin n_err++; $display("FAIL ferr_recover_data: got %h want a5", data_out); end
        idle(2);
        send_head(WIDTH'($urandom), 0);
        clr_err = 1'b1;
        send_bit(1'b0, 0);
        clr_err = 1'b0;
        n_cmp++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL ferr_set_wins: got %b want 1", frame_err); end
        send_bit(1'b1, 0);
        clear_flags();
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL ferr_clear2: got %b want 0", frame_err); end
        idle(2);
    endtask

    task automatic test_overrun();
        ready = 1'b0;
        idle(1);
        send_head(word_to_seq(8'h11), 0);
        send_bit(1'b1, 0);
        n_cmp++; if (valid !== 1'b1 || data_out !== 8'h11) begin n_err++; $display("FAIL ovr_first: got valid=%b data=%h want 1/11", valid, data_out); end
        idle(3);
        n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL ovr_hold_valid: got %b want 1", valid); end
        send_head(word_to_seq(8'h22), 0);
        send_bit(1'b1, 0);
        n_cmp++; if (data_out !== 8'h11) begin n_err++; $display("FAIL ovr_data_kept: got %h want 11", data_out); end
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_flag: got %b want 1", overrun); end
        n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid: got %b want 1", valid); end
        ready = 1'b1;
        tick();
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL ovr_accept: got %b want 0", valid); end
        clear_flags();
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clear: got %b want 0", overrun); end
        idle(2);
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] sa, sb;
        sa = WIDTH'($urandom);
        sb = WIDTH'($urandom);
        ready = 1'b0;
        send_head(sa, 0);
        send_bit(1'b1, 0);
        n_cmp++; if (valid !== 1'b1 || data_out !== model_word(sa)) begin n_err++; $display("FAIL b2b_first: got valid=%b data=%h want 1/%h", valid, data_out, model_word(sa)); end
        send_head(sb, 0);
        ready = 1'b1;
        send_bit(1'b1, 0);
        ready = 1'b0;
        n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid: got %b want 1", valid); end
        n_cmp++; if (data_out !== model_word(sb)) begin n_err++; $display("FAIL b2b_data: got %h want %h", data_out, model_word(sb)); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
        tick();
        n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL b2b_wait: got %b want 1", valid); end
        ready = 1'b1;
        tick();
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL b2b_accept2: got %b want 0", valid); end
        idle(2);
    endtask

    task automatic test_reset_mid();
        logic [WIDTH-1:0] s;
        s = WIDTH'($urandom);
        ready = 1'b1;
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(s[i], 0);
        arst_n = 1'b0;
        tick();
        arst_n = 1'b1;
        n_cmp++; if (valid !== 1'b0 || data_out !== '0) begin n_err++; $display("FAIL rmid_reset: got valid=%b data=%h want 0/0", valid, data_out); end
        in_line = 1'b1; in_en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL rmid_no_valid: cycle %0d got %b want 0", k, valid); end
        end
        in_en = 1'b0;
        s = WIDTH'($urandom);
        send_head(s, 0);
        send_bit(1'b1, 0);
        n_cmp++; if (valid !== 1'b1 || data_out !== model_word(s)) begin n_err++; $display("FAIL rmid_next: got valid=%b data=%h want 1/%h", valid, data_out, model_word(s)); end
        idle(2);
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] s;
        int gap;
        ready = 1'b1;
        for (int f = 0; f < 24; f++) begin
            s   = WIDTH'($urandom);
            gap = int'($urandom_range(0, 2));
            send_head(s, gap);
            send_bit(1'b1, 0);
            n_cmp++; if (valid !== 1'b1 || data_out !== model_word(s)) begin n_err++; $display("FAIL rand_frame%0d: got valid=%b data=%h want 1/%h", f, valid, data_out, model_word(s)); end
            idle(1 + int'($urandom_range(0, 2)));
            n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL rand_drop%0d: got %b want 0", f, valid); end
        end
        n_cmp++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin n_err++; $display("FAIL rand_flags: got ferr=%b ovr=%b want 0/0", frame_err, overrun); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_slow_strobe();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
